// File: rtl/freq_pkg.sv
// Shared constants and types for the frequency generator and meter.
package freq_pkg;

  localparam int unsigned F_CLK       = 50_000_000;
  localparam int unsigned F_MAX       = 12_500_000;
  localparam int unsigned BURST_W_DEF = 16;
  localparam int unsigned FREQ_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fg_state_e;

  // Requests above the maximum output frequency are stored as the maximum.
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f);
    return (f > FREQ_W'(F_MAX)) ? FREQ_W'(F_MAX) : f;
  endfunction

endpackage

// File: rtl/freq_gen_drive_phase_acc_toggle.sv
// Modulo-F_CLK phase accumulator; toggles out on each wrap and flags the
// rising/falling transition that the next edge will produce.
module phase_acc_toggle
  import freq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              drop,
  input  logic [FREQ_W-1:0] inc,
  output logic              out,
  output logic              rise_c,
  output logic              fall_c
);

  logic [FREQ_W-1:0] acc;
  logic [FREQ_W-1:0] sum_c;
  logic              wrap_c;

  always_comb begin
    sum_c  = acc + inc;
    wrap_c = (sum_c >= FREQ_W'(F_CLK));
    rise_c = en && wrap_c && !out;
    fall_c = en && wrap_c && out;
  end

  // drop forces the output low while freezing the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      out <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      out <= 1'b0;
    end else if (drop) begin
      out <= 1'b0;
    end else if (en) begin
      acc <= wrap_c ? (sum_c - FREQ_W'(F_CLK)) : sum_c;
      if (wrap_c) out <= ~out;
    end
  end

endmodule

// File: rtl/freq_gen_drive.sv
// Programmable square-wave generator with continuous/burst modes and
// period-boundary config updates through a valid/ready handshake.
module freq_gen_drive
  import freq_pkg::*;
#(
  parameter int unsigned BURST_W  = BURST_W_DEF,
  parameter int unsigned DEF_FREQ = 1_000
) (
  input  logic               in_clk_50M,
  input  logic               in_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_freq,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               sig_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  fg_state_e          state, state_d;
  logic [FREQ_W-1:0]  freq_act, freq_d, sh_freq, sh_freq_d, cfg_freq_cl_c, inc_c;
  logic [BURST_W-1:0] burst_act, burst_d, sh_burst, sh_burst_d, cnt_d, cnt_inc_c;
  logic               pend, pend_d, done_d;
  logic               xfer_c, to_idle_c, acc_en_c, acc_clr_c, acc_drop_c;
  logic               rise_c, fall_c;

  assign xfer_c        = cfg_valid && cfg_ready;
  assign cfg_freq_cl_c = clamp_freq(cfg_freq);
  assign cnt_inc_c     = (&pulse_cnt) ? pulse_cnt : pulse_cnt + BURST_W'(1);
  assign inc_c         = {freq_act[FREQ_W-2:0], 1'b0};
  assign acc_en_c      = (state != IDLE);

  phase_acc_toggle u_acc (
    .clk    (in_clk_50M),
    .rst_n  (in_clr),
    .en     (acc_en_c),
    .clr    (acc_clr_c),
    .drop   (acc_drop_c),
    .inc    (inc_c),
    .out    (sig_out),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    state_d    = state;
    freq_d     = freq_act;
    burst_d    = burst_act;
    sh_freq_d  = sh_freq;
    sh_burst_d = sh_burst;
    pend_d     = pend;
    cnt_d      = pulse_cnt;
    done_d     = 1'b0;
    to_idle_c  = 1'b0;
    acc_clr_c  = 1'b0;
    acc_drop_c = 1'b0;
    case (state)
      IDLE: begin
        if (xfer_c) begin
          freq_d  = cfg_freq_cl_c;
          burst_d = cfg_burst;
        end
        if (start && !stop && (freq_act != '0)) begin
          state_d   = RUN;
          acc_clr_c = 1'b1;
          cnt_d     = '0;
        end
      end
      RUN, DRAIN: begin
        // A falling edge is always counted before stop/update decisions.
        if ((state == DRAIN) && (freq_act == '0)) begin
          acc_drop_c = 1'b1;
          to_idle_c  = 1'b1;
          if (sig_out) cnt_d = cnt_inc_c;
        end else if (fall_c) begin
          cnt_d = cnt_inc_c;
          if ((state == DRAIN) || stop || ((burst_act != '0) && (cnt_inc_c == burst_act)))
            to_idle_c = 1'b1;
        end else if ((state == RUN) && stop) begin
          if (sig_out) begin
            state_d = DRAIN;
          end else begin
            acc_drop_c = 1'b1;
            to_idle_c  = 1'b1;
          end
        end else if (rise_c && pend) begin
          freq_d  = sh_freq;
          burst_d = sh_burst;
          pend_d  = 1'b0;
          if (sh_freq == '0) state_d = DRAIN;
        end
        // Leaving for IDLE flushes any queued config so the handshake reopens.
        if (to_idle_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pend_d  = 1'b0;
          if (pend) begin
            freq_d  = sh_freq;
            burst_d = sh_burst;
          end else if (xfer_c) begin
            freq_d  = cfg_freq_cl_c;
            burst_d = cfg_burst;
          end
        end else if (xfer_c) begin
          sh_freq_d  = cfg_freq_cl_c;
          sh_burst_d = cfg_burst;
          pend_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk_50M or negedge in_clr) begin
    if (!in_clr) begin
      state     <= IDLE;
      freq_act  <= FREQ_W'(DEF_FREQ);
      burst_act <= '0;
      sh_freq   <= '0;
      sh_burst  <= '0;
      pend      <= 1'b0;
      pulse_cnt <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_d;
      freq_act  <= freq_d;
      burst_act <= burst_d;
      sh_freq   <= sh_freq_d;
      sh_burst  <= sh_burst_d;
      pend      <= pend_d;
      pulse_cnt <= cnt_d;
      done      <= done_d;
      busy      <= (state_d != IDLE);
      cfg_ready <= !pend_d;
    end
  end

endmodule

// File: tb/tb_freq_gen_drive.sv
// Self-checking bench for freq_gen_drive: cycle model plus directed waveform checks.
module tb_freq_gen_drive;

  localparam longint F_CLK    = 50_000_000;
  localparam longint F_MAX    = 12_500_000;
  localparam longint DEF_FREQ = 1_000;
  localparam int     BW       = 16;

  logic          in_clk_50M = 1'b0;
  logic          in_clr     = 1'b0;
  logic          cfg_valid  = 1'b0;
  logic [31:0]   cfg_freq   = '0;
  logic [BW-1:0] cfg_burst  = '0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
  logic          cfg_ready, sig_out, busy, done;
  logic [BW-1:0] pulse_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  freq_gen_drive dut (
    .in_clk_50M (in_clk_50M),
    .in_clr     (in_clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_freq   (cfg_freq),
    .cfg_burst  (cfg_burst),
    .start      (start),
    .stop       (stop),
    .sig_out    (sig_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #10 in_clk_50M = ~in_clk_50M;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: generator behaviour as a phase count against F_CLK, one step per clock.
  bit     m_busy = 0, m_drain = 0, m_sig = 0, m_done = 0, m_pend = 0;
  longint m_acc = 0, m_freq = DEF_FREQ, m_burst = 0, m_sh_f = 0, m_sh_b = 0, m_cnt = 0;

  always @(posedge in_clk_50M or negedge in_clr) begin : model
    bit     xfer, wrap, to_idle;
    longint s, ci, cf;
    if (!in_clr) begin
      m_busy = 0; m_drain = 0; m_sig = 0; m_done = 0; m_pend = 0;
      m_acc = 0; m_freq = DEF_FREQ; m_burst = 0; m_sh_f = 0; m_sh_b = 0; m_cnt = 0;
    end else begin
      xfer   = cfg_valid && !m_pend;
      cf     = (longint'(cfg_freq) > F_MAX) ? F_MAX : longint'(cfg_freq);
      m_done = 0;
      if (!m_busy) begin
        if (start && !stop && m_freq != 0) begin
          m_busy = 1; m_drain = 0; m_acc = 0; m_sig = 0; m_cnt = 0;
        end
        if (xfer) begin m_freq = cf; m_burst = longint'(cfg_burst); end
      end else begin
        s       = m_acc + 2 * m_freq;
        wrap    = (s >= F_CLK);
        ci      = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        to_idle = 0;
        if (m_drain && m_freq == 0) begin
          if (m_sig) m_cnt = ci;
          m_sig = 0; to_idle = 1;
        end else if (wrap && m_sig) begin
          m_sig = 0; m_acc = s - F_CLK; m_cnt = ci;
          to_idle = m_drain || stop || (m_burst != 0 && ci == m_burst);
        end else if (!m_drain && stop) begin
          if (m_sig) begin m_drain = 1; m_acc = s; end
          else to_idle = 1;
        end else begin
          m_acc = wrap ? s - F_CLK : s;
          if (wrap) begin
            m_sig = 1;
            if (m_pend) begin
              m_freq = m_sh_f; m_burst = m_sh_b; m_pend = 0;
              if (m_freq == 0) m_drain = 1;
            end
          end
        end
        if (to_idle) begin
          m_busy = 0; m_drain = 0; m_done = 1;
          if (m_pend) begin m_freq = m_sh_f; m_burst = m_sh_b; end
          else if (xfer) begin m_freq = cf; m_burst = longint'(cfg_burst); end
          m_pend = 0;
        end else if (xfer) begin
          m_sh_f = cf; m_sh_b = longint'(cfg_burst); m_pend = 1;
        end
      end
    end
  end

  always @(negedge in_clk_50M) begin
    if (in_clr) begin
      check("cyc_sig_out", sig_out, m_sig);
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_pulse_cnt", pulse_cnt, m_cnt);
      check("cyc_cfg_ready", cfg_ready, !m_pend);
    end
  end

  task automatic wait_sig(input logic lvl, input int lim, output int n);
    n = 0;
    while (sig_out !== lvl && n < lim) begin
      @(negedge in_clk_50M);
      n++;
    end
    if (sig_out !== lvl) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_sig: sig_out not %0b after %0d cycles", lvl, lim);
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge in_clk_50M);
      n++;
    end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", lim);
    end
  endtask

  task automatic cfg_idle(input longint f, input int b);
    cfg_valid = 1'b1; cfg_freq = 32'(f); cfg_burst = BW'(b);
    @(negedge in_clk_50M);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge in_clk_50M);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge in_clk_50M);
    stop = 1'b0;
  endtask

  initial begin : main
    int n, n2, n3;
    repeat (3) @(negedge in_clk_50M);
    check("rst_sig_out", sig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    in_clr = 1'b1;
    @(negedge in_clk_50M);

    // Continuous 1 MHz, then graceful stop 5 clocks after a rise.
    cfg_idle(1_000_000, 0);
    pulse_start();
    wait_sig(1'b1, 100, n);  check("c1m_first_rise", n, 25);
    wait_sig(1'b0, 100, n2); check("c1m_high", n2, 25);
    wait_sig(1'b1, 100, n3); check("c1m_low", n3, 25);
    repeat (500 - n - n2 - n3) @(negedge in_clk_50M);
    check("c1m_cnt_500", pulse_cnt, 10);
    wait_sig(1'b1, 100, n);
    repeat (4) @(negedge in_clk_50M);
    pulse_stop();
    check("stop_busy_drain", busy, 1);
    check("stop_sig_high", sig_out, 1);
    wait_sig(1'b0, 100, n);  check("stop_fall_delay", n, 20);
    check("stop_done", done, 1);
    check("stop_busy", busy, 0);
    check("stop_cnt", pulse_cnt, 11);
    @(negedge in_clk_50M);
    check("stop_done_once", done, 0);
    start = 1'b1; stop = 1'b1;
    @(negedge in_clk_50M);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", busy, 0);
    repeat (30) @(negedge in_clk_50M);
    check("start_stop_sig", sig_out, 0);
    check("start_stop_cnt", pulse_cnt, 11);

    // Clamp 20 MHz -> 12.5 MHz.
    cfg_idle(20_000_000, 0);
    pulse_start();
    wait_sig(1'b1, 20, n); check("clamp_first_rise", n, 2);
    wait_sig(1'b0, 20, n); check("clamp_high", n, 2);
    wait_sig(1'b1, 20, n); check("clamp_low", n, 2);
    pulse_stop();
    wait_idle(20);

    // Burst of 3 at 5 MHz.
    cfg_idle(5_000_000, 3);
    pulse_start();
    wait_sig(1'b1, 50, n); check("burst_first_rise", n, 5);
    for (int p = 1; p <= 3; p++) begin
      wait_sig(1'b0, 50, n); check("burst_high", n, 5);
      check("burst_done", done, (p == 3) ? 1 : 0);
      if (p < 3) begin
        wait_sig(1'b1, 50, n); check("burst_low", n, 5);
      end
    end
    check("burst_busy", busy, 0);
    check("burst_cnt", pulse_cnt, 3);
    repeat (40) @(negedge in_clk_50M);
    check("burst_sig_after", sig_out, 0);
    check("burst_cnt_held", pulse_cnt, 3);

    // Mid-run update 1 MHz -> 2 MHz, offered during the high phase.
    cfg_idle(1_000_000, 0);
    pulse_start();
    wait_sig(1'b1, 100, n);
    repeat (5) @(negedge in_clk_50M);
    cfg_valid = 1'b1; cfg_freq = 32'd2_000_000; cfg_burst = '0;
    @(negedge in_clk_50M);
    cfg_valid = 1'b0;
    check("upd_ready_low", cfg_ready, 0);
    wait_sig(1'b0, 100, n);
    check("upd_ready_low_fall", cfg_ready, 0);
    wait_sig(1'b1, 100, n);
    check("upd_ready_back", cfg_ready, 1);
    wait_sig(1'b0, 100, n2); check("upd_high", n2, 13);
    wait_sig(1'b1, 100, n3); check("upd_period", n2 + n3, 25);
    pulse_stop();
    wait_idle(50);

    // Async reset mid-high, then restart at the default frequency.
    cfg_idle(1_000_000, 0);
    pulse_start();
    wait_sig(1'b1, 100, n);
    repeat (3) @(negedge in_clk_50M);
    #2 in_clr = 1'b0;
    #1;
    check("arst_sig_out", sig_out, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_cnt", pulse_cnt, 0);
    @(negedge in_clk_50M);
    in_clr = 1'b1;
    @(negedge in_clk_50M);
    pulse_start();
    wait_sig(1'b1, 30000, n); check("def_first_rise", n, 25000);
    #2 in_clr = 1'b0;
    @(negedge in_clk_50M);
    in_clr = 1'b1;
    @(negedge in_clk_50M);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 300; c++) begin
        start     = ($urandom_range(0, 39) == 0);
        stop      = ($urandom_range(0, 59) == 0);
        cfg_valid = ($urandom_range(0, 14) == 0);
        case ($urandom_range(0, 6))
          0:       cfg_freq = 32'd0;
          1:       cfg_freq = 32'd1_000_000;
          2:       cfg_freq = 32'd2_500_000;
          3:       cfg_freq = 32'd5_000_000;
          4:       cfg_freq = 32'd12_500_000;
          5:       cfg_freq = 32'($urandom_range(12_500_001, 40_000_000));
          default: cfg_freq = 32'($urandom_range(800_000, 13_000_000));
        endcase
        cfg_burst = BW'($urandom_range(0, 4));
        @(negedge in_clk_50M);
      end
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    repeat (5) @(negedge in_clk_50M);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
